// File: rtl/brick_mem_arbiter.sv
// brick_mem_arbiter
//
// Arbiter and sequencer for the single-port brick-health memory. Two requesters
// share the memory: the ball collision logic (read/write, addressed by pixel
// coordinate) and the draw engine (read only, addressed by column/row). Pixel
// coordinates are converted to a brick address, one fixed-latency access is run,
// and health plus the brick's top-left pixel are returned to the winner.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   b_req/b_we/b_x/b_y/b_wdata   ball request, write flag, pixel coordinate, write data
//   b_ack/b_rdata                ball completion pulse and read health
//   b_brickx/b_bricky            top-left pixel of the brick addressed by the ball
//   d_req/d_col/d_row            draw request and brick index
//   d_ack/d_rdata                draw completion pulse and read health
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port (read data 1 cycle after mem_en)
//   busy                         high whenever the sequencer is not idle
//
// Configuration macro:
//   BRICK_ARB_RR_EN  defined   -> round-robin arbitration between ball and draw
//                    undefined -> fixed priority, ball always wins

module brick_mem_arbiter #(
    parameter int unsigned BRICK_W = 40,
    parameter int unsigned BRICK_H = 20,
    parameter int unsigned COLS    = 16,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [9:0]        b_x,
    input  logic [9:0]        b_y,
    input  logic [1:0]        b_wdata,
    output logic              b_ack,
    output logic [1:0]        b_rdata,
    output logic [9:0]        b_brickx,
    output logic [9:0]        b_bricky,
    input  logic              d_req,
    input  logic [3:0]        d_col,
    input  logic [2:0]        d_row,
    output logic              d_ack,
    output logic [1:0]        d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [9:0] BrickW10 = 10'(BRICK_W);
    localparam logic [9:0] BrickH10 = 10'(BRICK_H);
    localparam logic [9:0] Cols10   = 10'(COLS);
    localparam logic [9:0] Rows10   = 10'(ROWS);

    state_t      state;
    logic        gnt_ball;
    logic        op_we;
    logic        op_in_range;
    logic [9:0]  op_brickx;
    logic [9:0]  op_bricky;

    // Ball-side address decode: constant division, so this maps to fixed logic.
    logic [9:0]        b_col;
    logic [9:0]        b_row;
    logic [9:0]        b_px;
    logic [9:0]        b_py;
    logic              b_in_range;
    logic [ADDR_W-1:0] b_addr;

    assign b_col      = b_x / BrickW10;
    assign b_row      = b_y / BrickH10;
    assign b_px       = b_col * BrickW10;
    assign b_py       = b_row * BrickH10;
    assign b_in_range = (b_col < Cols10) && (b_row < Rows10);
    assign b_addr     = ADDR_W'(b_row) * ADDR_W'(COLS) + ADDR_W'(b_col);

    logic              d_in_range;
    logic [ADDR_W-1:0] d_addr;

    assign d_in_range = ({6'd0, d_col} < Cols10) && ({7'd0, d_row} < Rows10);
    assign d_addr     = ADDR_W'(d_row) * ADDR_W'(COLS) + ADDR_W'(d_col);

    // Arbitration
    logic pick_ball;
`ifdef BRICK_ARB_RR_EN
    logic last_ball;  // 1: ball was granted last, 0: draw was granted last
    assign pick_ball = b_req && (!d_req || !last_ball);
`else
    assign pick_ball = b_req;
`endif

    logic              sel_in_range;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;

    assign sel_in_range = pick_ball ? b_in_range : d_in_range;
    assign sel_we       = pick_ball && b_we;
    assign sel_addr     = pick_ball ? b_addr : d_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            gnt_ball    <= 1'b0;
            op_we       <= 1'b0;
            op_in_range <= 1'b0;
            op_brickx   <= '0;
            op_bricky   <= '0;
            b_ack       <= 1'b0;
            b_rdata     <= '0;
            b_brickx    <= '0;
            b_bricky    <= '0;
            d_ack       <= 1'b0;
            d_rdata     <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
`ifdef BRICK_ARB_RR_EN
            last_ball   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (b_req || d_req) begin
                        gnt_ball    <= pick_ball;
                        op_we       <= sel_we;
                        op_in_range <= sel_in_range;
                        if (pick_ball) begin
                            op_brickx <= b_px;
                            op_bricky <= b_py;
                        end
                        // Strobes are registered so they are live during S_ISSUE.
                        mem_en <= sel_in_range;
                        mem_we <= sel_in_range && sel_we;
                        if (sel_in_range) mem_addr <= sel_addr;
                        if (sel_in_range && sel_we) mem_wdata <= b_wdata;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
`ifdef BRICK_ARB_RR_EN
                        last_ball <= pick_ball;
`endif
                    end
                end
                S_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (op_in_range && !op_we) begin
                        state <= S_WAIT;
                    end else begin
                        // Writes and out-of-range accesses complete with zero health.
                        state <= S_DONE;
                        if (gnt_ball) begin
                            b_ack    <= 1'b1;
                            b_rdata  <= '0;
                            b_brickx <= op_brickx;
                            b_bricky <= op_bricky;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    state <= S_DONE;
                    if (gnt_ball) begin
                        b_ack    <= 1'b1;
                        b_rdata  <= mem_rdata;
                        b_brickx <= op_brickx;
                        b_bricky <= op_bricky;
                    end else begin
                        d_ack   <= 1'b1;
                        d_rdata <= mem_rdata;
                    end
                end
                S_DONE: begin
                    b_ack <= 1'b0;
                    d_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_mem_arbiter.sv
module tb_brick_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       b_req = 1'b0;
    logic       b_we = 1'b0;
    logic [9:0] b_x = '0;
    logic [9:0] b_y = '0;
    logic [1:0] b_wdata = '0;
    logic       b_ack;
    logic [1:0] b_rdata;
    logic [9:0] b_brickx;
    logic [9:0] b_bricky;
    logic       d_req = 1'b0;
    logic [3:0] d_col = '0;
    logic [2:0] d_row = '0;
    logic       d_ack;
    logic [1:0] d_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = '0;
    logic       busy;

    brick_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_x       (b_x),
        .b_y       (b_y),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .b_brickx  (b_brickx),
        .b_bricky  (b_bricky),
        .d_req     (d_req),
        .d_col     (d_col),
        .d_row     (d_row),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT: one-cycle read latency.
    logic [1:0] mem [0:127];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference copy of brick health, updated only from the bench's own model.
    int ref_mem [0:127];

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one transaction
    int o_ack_cyc, o_en_cyc, o_en_cnt, o_we_cnt, o_addr, o_wdata;
    int o_rdata, o_bx, o_by, o_wrong_ack, o_busy_bad;

    // Expected results from the specification's arithmetic
    function automatic void model(input bit is_ball, input int x, input int y, input int col,
                                  input int row, output bit inr, output int addr,
                                  output int px, output int py);
        int c, r;
        c = is_ball ? x / 40 : col;
        r = is_ball ? y / 20 : row;
        inr  = (c < 16) && (r < 8);
        addr = r * 16 + c;
        px   = (c * 40) % 1024;
        py   = (r * 20) % 1024;
    endfunction

    // Issue one request in an idle cycle (cycle 0) and record what happens.
    task automatic drive_txn(input bit is_ball, input int x, input int y, input bit we,
                             input int wd, input int col, input int row);
        if (is_ball) begin
            b_x = 10'(x); b_y = 10'(y); b_we = we; b_wdata = 2'(wd); b_req = 1'b1;
        end else begin
            d_col = 4'(col); d_row = 3'(row); d_req = 1'b1;
        end
        o_ack_cyc = -1; o_en_cyc = -1; o_en_cnt = 0; o_we_cnt = 0; o_addr = -1;
        o_wdata = -1; o_rdata = -1; o_bx = -1; o_by = -1; o_wrong_ack = 0; o_busy_bad = 0;
        for (int cyc = 1; cyc <= 8 && o_ack_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            if (!busy) o_busy_bad++;
            if (mem_en) begin
                o_en_cnt++;
                o_en_cyc = cyc;
                o_addr   = int'(mem_addr);
                if (mem_we) begin
                    o_we_cnt++;
                    o_wdata = int'(mem_wdata);
                end
            end
            if (is_ball ? d_ack : b_ack) o_wrong_ack++;
            if (is_ball ? b_ack : d_ack) begin
                o_ack_cyc = cyc;
                o_rdata   = is_ball ? int'(b_rdata) : int'(d_rdata);
                o_bx      = int'(b_brickx);
                o_by      = int'(b_bricky);
            end
        end
        b_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, b_ack, d_ack, mem_en, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000", {busy, b_ack, d_ack, mem_en, mem_we});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, b_rdata, d_rdata, b_brickx, b_bricky} !== 33'b0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d wd=%0d brd=%0d drd=%0d bx=%0d by=%0d required all 0",
                     mem_addr, mem_wdata, b_rdata, d_rdata, b_brickx, b_bricky);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ball_read;
        mem[34] = 2'd3; ref_mem[34] = 3;
        drive_txn(1'b1, 85, 45, 1'b0, 0, 0, 0);
        n_checks++;
        if (o_en_cyc != 1 || o_en_cnt != 1 || o_we_cnt != 0 || o_addr != 34) begin
            n_fail++;
            $display("FAIL ball_read_mem: en_cyc=%0d en_cnt=%0d we_cnt=%0d addr=%0d required 1 1 0 34",
                     o_en_cyc, o_en_cnt, o_we_cnt, o_addr);
        end
        n_checks++;
        if (o_ack_cyc != 3 || o_rdata != 3 || o_bx != 80 || o_by != 40) begin
            n_fail++;
            $display("FAIL ball_read_ack: cyc=%0d rdata=%0d bx=%0d by=%0d required 3 3 80 40",
                     o_ack_cyc, o_rdata, o_bx, o_by);
        end
        n_checks++;
        if (o_wrong_ack != 0 || o_busy_bad != 0) begin
            n_fail++;
            $display("FAIL ball_read_side: d_acks=%0d idle_cycles=%0d required 0 0",
                     o_wrong_ack, o_busy_bad);
        end
        n_checks++;
        if (b_rdata !== 2'd3 || b_brickx !== 10'd80) begin
            n_fail++;
            $display("FAIL ball_read_hold: rdata=%0d bx=%0d required 3 80", b_rdata, b_brickx);
        end
    endtask

    task automatic test_ball_write;
        drive_txn(1'b1, 0, 0, 1'b1, 1, 0, 0);
        ref_mem[0] = 1;
        n_checks++;
        if (o_en_cyc != 1 || o_en_cnt != 1 || o_we_cnt != 1 || o_addr != 0 || o_wdata != 1) begin
            n_fail++;
            $display("FAIL ball_write_mem: en_cyc=%0d en=%0d we=%0d addr=%0d wd=%0d required 1 1 1 0 1",
                     o_en_cyc, o_en_cnt, o_we_cnt, o_addr, o_wdata);
        end
        n_checks++;
        if (o_ack_cyc != 2 || o_rdata != 0 || o_bx != 0 || o_by != 0) begin
            n_fail++;
            $display("FAIL ball_write_ack: cyc=%0d rdata=%0d bx=%0d by=%0d required 2 0 0 0",
                     o_ack_cyc, o_rdata, o_bx, o_by);
        end
        drive_txn(1'b1, 39, 19, 1'b0, 0, 0, 0);
        n_checks++;
        if (o_ack_cyc != 3 || o_rdata != ref_mem[0]) begin
            n_fail++;
            $display("FAIL ball_write_readback: cyc=%0d rdata=%0d required 3 %0d",
                     o_ack_cyc, o_rdata, ref_mem[0]);
        end
    endtask

    task automatic test_draw_read;
        mem[127] = 2'd2; ref_mem[127] = 2;
        drive_txn(1'b0, 0, 0, 1'b0, 0, 15, 7);
        n_checks++;
        if (o_en_cyc != 1 || o_en_cnt != 1 || o_we_cnt != 0 || o_addr != 127) begin
            n_fail++;
            $display("FAIL draw_read_mem: en_cyc=%0d en=%0d we=%0d addr=%0d required 1 1 0 127",
                     o_en_cyc, o_en_cnt, o_we_cnt, o_addr);
        end
        n_checks++;
        if (o_ack_cyc != 3 || o_rdata != 2 || o_wrong_ack != 0) begin
            n_fail++;
            $display("FAIL draw_read_ack: cyc=%0d rdata=%0d b_acks=%0d required 3 2 0",
                     o_ack_cyc, o_rdata, o_wrong_ack);
        end
    endtask

    task automatic test_out_of_range;
        drive_txn(1'b1, 700, 45, 1'b0, 0, 0, 0);
        n_checks++;
        if (o_en_cnt != 0 || o_ack_cyc != 2 || o_rdata != 0 || o_bx != 680 || o_by != 40) begin
            n_fail++;
            $display("FAIL oor_x: en=%0d cyc=%0d rdata=%0d bx=%0d by=%0d required 0 2 0 680 40",
                     o_en_cnt, o_ack_cyc, o_rdata, o_bx, o_by);
        end
        drive_txn(1'b1, 100, 170, 1'b1, 3, 0, 0);
        n_checks++;
        if (o_en_cnt != 0 || o_we_cnt != 0 || o_ack_cyc != 2 || o_rdata != 0 || o_by != 160) begin
            n_fail++;
            $display("FAIL oor_y_write: en=%0d we=%0d cyc=%0d rdata=%0d by=%0d required 0 0 2 0 160",
                     o_en_cnt, o_we_cnt, o_ack_cyc, o_rdata, o_by);
        end
    endtask

    task automatic test_random;
        bit is_ball, we, inr;
        int x, y, col, row, wd, addr, px, py, exp_cyc, exp_rd;
        for (int i = 0; i < 40; i++) begin
            is_ball = 1'($urandom_range(0, 1));
            we      = is_ball && ($urandom_range(0, 2) == 0);
            x   = int'($urandom_range(0, 719));
            y   = int'($urandom_range(0, 179));
            col = int'($urandom_range(0, 15));
            row = int'($urandom_range(0, 7));
            wd  = int'($urandom_range(0, 3));
            model(is_ball, x, y, col, row, inr, addr, px, py);
            exp_cyc = (inr && !we) ? 3 : 2;
            exp_rd  = (inr && !we) ? ref_mem[addr] : 0;
            drive_txn(is_ball, x, y, we, wd, col, row);
            if (inr && we) ref_mem[addr] = wd;
            n_checks++;
            if (o_ack_cyc != exp_cyc || o_rdata != exp_rd || o_wrong_ack != 0) begin
                n_fail++;
                $display("FAIL rand_ack[%0d]: cyc=%0d rdata=%0d other=%0d required %0d %0d 0",
                         i, o_ack_cyc, o_rdata, o_wrong_ack, exp_cyc, exp_rd);
            end
            n_checks++;
            if (o_en_cnt != (inr ? 1 : 0) || o_we_cnt != ((inr && we) ? 1 : 0)
                || (inr && o_addr != addr) || (inr && we && o_wdata != wd)) begin
                n_fail++;
                $display("FAIL rand_mem[%0d]: en=%0d we=%0d addr=%0d wd=%0d required inr=%0d we=%0d addr=%0d wd=%0d",
                         i, o_en_cnt, o_we_cnt, o_addr, o_wdata, inr, we, addr, wd);
            end
            if (is_ball) begin
                n_checks++;
                if (o_bx != px || o_by != py) begin
                    n_fail++;
                    $display("FAIL rand_brick[%0d]: bx=%0d by=%0d required %0d %0d",
                             i, o_bx, o_by, px, py);
                end
            end
        end
    endtask

    task automatic test_contention;
        int who [$];
        int when [$];
        int exp_who;
        bit idle_seen;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b_x = 10'd85; b_y = 10'd45; b_we = 1'b0; d_col = 4'd15; d_row = 3'd7;
        b_req = 1'b1; d_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (b_ack) begin who.push_back(0); when.push_back(cyc); end
            if (d_ack) begin who.push_back(1); when.push_back(cyc); end
        end
        b_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (who.size() != 5) begin
            n_fail++;
            $display("FAIL contention_count: acks=%0d required 5", who.size());
        end
        for (int k = 0; k < who.size() && k < 5; k++) begin
`ifdef BRICK_ARB_RR_EN
            exp_who = k % 2;
`else
            exp_who = 0;
`endif
            n_checks++;
            if (who[k] != exp_who || when[k] != 4 * k + 3) begin
                n_fail++;
                $display("FAIL contention_ack[%0d]: who=%0d cyc=%0d required %0d %0d",
                         k, who[k], when[k], exp_who, 4 * k + 3);
            end
        end
        idle_seen = 1'b0;
        for (int cyc = 0; cyc < 8 && !idle_seen; cyc++) begin
            @(posedge clk); #1;
            if (!busy) idle_seen = 1'b1;
        end
        n_checks++;
        if (!idle_seen) begin
            n_fail++;
            $display("FAIL contention_drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int ack_cyc, rd;
        mem[21] = 2'd2; ref_mem[21] = 2;
        b_x = 10'd200; b_y = 10'd20; b_we = 1'b0; b_req = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, b_ack, d_ack, mem_en, mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: busy/acks/strobes=%b required 00000",
                     {busy, b_ack, d_ack, mem_en, mem_we});
        end
        #1;
        reset = 1'b0;
        ack_cyc = -1; rd = -1;
        for (int cyc = 1; cyc <= 8 && ack_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            if (b_ack) begin ack_cyc = cyc; rd = int'(b_rdata); end
        end
        b_req = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (ack_cyc != 3 || rd != ref_mem[21]) begin
            n_fail++;
            $display("FAIL reset_restart: cyc=%0d rdata=%0d required 3 %0d", ack_cyc, rd, ref_mem[21]);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 2'($urandom_range(0, 3));
            ref_mem[i] = int'(mem[i]);
        end
        test_reset;
        test_ball_read;
        test_ball_write;
        test_draw_read;
        test_out_of_range;
        test_random;
        test_reset_mid;
        test_contention;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brick_mem_arbiter.md
# brick_mem_arbiter

Arbiter and sequencer for the single-port brick-health memory. It serves two requesters: the ball collision logic, which reads and writes a brick addressed by pixel coordinate, and the draw engine, which reads a brick addressed by column/row index. It converts pixel coordinates to a brick address, runs a fixed-latency memory access, and returns health and the brick's top-left pixel coordinates to the requester.

## Interface
Parameters:
- BRICK_W, 40: brick width in pixels.
- BRICK_H, 20: brick height in pixels.
- COLS, 16: bricks per row.
- ROWS, 8: brick rows.
- ADDR_W, 7: memory address width; must satisfy 2^ADDR_W >= COLS*ROWS.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- b_req  in  1  ball request; held until b_ack.
- b_we  in  1  ball write (1) / read (0); stable while b_req.
- b_x, b_y  in  10 each  ball-side pixel coordinate.
- b_wdata  in  2  health to write.
- b_ack  out  1  one-cycle completion pulse.
- b_rdata  out  2  health read; 0 for writes and out-of-range accesses.
- b_brickx, b_bricky  out  10 each  top-left pixel of the addressed brick.
- d_req  in  1  draw request; held until d_ack.
- d_col  in  4  draw column index.
- d_row  in  3  draw row index.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  2  health read.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  2  memory write data.
- mem_rdata  in  2  memory read data, valid 1 cycle after mem_en.
- busy  out  1  high in any state other than S_IDLE.

## Operation
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_DONE.
- S_IDLE: if either request is high, arbitrate, latch the winner, its address and its write data, then go to S_ISSUE. Otherwise stay in S_IDLE.
- Ball address: col = b_x / BRICK_W and row = b_y / BRICK_H, both integer division by constants. mem_addr = row*COLS + col. b_brickx = col*BRICK_W and b_bricky = row*BRICK_H, truncated to 10 bits.
- Draw address: mem_addr = d_row*COLS + d_col.
- Out of range (col >= COLS or row >= ROWS):
  - mem_en and mem_we stay low.
  - The FSM goes S_ISSUE -> S_DONE.
  - rdata is 0.
  - b_brickx/b_bricky still report the computed values.
- S_ISSUE, in range:
  - mem_en = 1 and mem_addr is driven.
  - For a write, mem_we = 1 and mem_wdata = latched b_wdata, then go to S_DONE.
  - For a read, go to S_WAIT.
- S_WAIT: capture mem_rdata into the winner's rdata register, then go to S_DONE.
- S_DONE: pulse the winner's ack for one cycle, then go to S_IDLE.
- rdata and b_brickx/b_bricky hold until the next ack to the same requester.
- Handshake rule: the requester deasserts req on the edge that ends its ack cycle. A req still high in S_IDLE is treated as a new request.
- Arbitration default: fixed priority; ball beats draw.
- Reset (asynchronous, any state, including mid-access):
  - FSM -> S_IDLE.
  - All outputs are 0.
  - Round-robin pointer = "draw last".
  - An interrupted write is not retried.

## Timing
- Read: req seen in S_IDLE at cycle 0; mem_en at cycle 1; capture at cycle 2; ack at cycle 3.
- Write or out-of-range: ack at cycle 2.
- mem_en and mem_we are high for exactly one cycle per in-range access.
- Minimum spacing between back-to-back grants: 4 cycles for reads, 3 for writes.

## Configuration
- BRICK_ARB_RR_EN defined: round-robin arbitration.
  - When both requests are high in S_IDLE, grant the requester not granted last.
  - A single requester is always granted.
  - The pointer updates at grant.
- Undefined: fixed priority, ball always wins; draw can starve under continuous ball requests.

## Test plan
- Ball read at b_x=85, b_y=45, mem_rdata=3:
  - mem_addr=34 with mem_en at cycle 1.
  - b_ack at cycle 3 with b_rdata=3, b_brickx=80, b_bricky=40.
- Ball write at b_x=0, b_y=0, b_wdata=1:
  - mem_we=1, mem_addr=0, mem_wdata=1 for one cycle at cycle 1.
  - b_ack at cycle 2 with b_rdata=0.
- Draw read at d_col=15, d_row=7 -> mem_addr=127; d_ack at cycle 3 with the memory value.
- Ball read at b_x=700 -> no mem_en; b_ack at cycle 2 with b_rdata=0.
- Both requests high continuously, reads only:
  - With BRICK_ARB_RR_EN: the ack sequence is b, d, b, d.
  - Without it: b_ack on every grant and no d_ack.
- reset asserted during S_WAIT:
  - busy, acks and mem strobes drop to 0 immediately.
  - After release with b_req still held, the access restarts and b_ack arrives at cycle 3 relative to the first S_IDLE.
